pc_gen: RTL

Parametrised fetch program-counter generator for the HYmips front end, sitting between the pipeline control unit and the instruction-memory port. It holds the fetch PC, a startup chip-enable, and N prioritised redirect channels (e.g. exception, branch, jump). A redirect that arrives while fetch is stalled is held as pending and applied on the next advance, not dropped. Fetch issue uses a valid/ready handshake with the instruction memory.

---
 rtl/pc_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for the HYmips front end.
// It holds the fetch PC and a startup chip-enable, and it arbitrates N
// prioritised redirect channels. A redirect that arrives while fetch cannot
// advance is parked in a single pending slot and applied on the next step.
module pc_gen #(
  parameter int              AW          = 32,
  parameter logic [AW-1:0]   RESET_ADDR  = AW'(32'h8000_0000),
  parameter int              FETCH_BYTES = 4,
  parameter int              N_REDIR     = 3,
  parameter int              STALL_W     = 6,
  parameter int              STALL_BIT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic [N_REDIR-1:0]    redir_valid,
  input  logic [N_REDIR*AW-1:0] redir_addr,
  input  logic                  fetch_ready,
  output logic [AW-1:0]         pc,
  output logic                  ce,
  output logic                  fetch_valid,
  output logic                  pc_misaligned,
  output logic [N_REDIR-1:0]    redir_taken,
  output logic                  redir_pending
);

  // Low address bits that must be zero for an aligned fetch. The mask is all
  // zero when FETCH_BYTES = 1, so pc_misaligned is then constant 0.
  localparam logic [AW-1:0] OFF_MASK = AW'(FETCH_BYTES - 1);
  localparam logic [AW-1:0] PC_INC   = AW'(FETCH_BYTES);

  logic                pending;
  logic [AW-1:0]       pending_addr;
  logic                win_valid;
  logic [AW-1:0]       win_addr;
  logic [N_REDIR-1:0]  win_onehot;
  logic                stalled;
  logic                step;
  logic [AW-1:0]       next_pc;

  // Only one bit of the stall vector belongs to this stage; the rest is
  // folded here so the unused bits are visibly intentional.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign stalled       = stall[STALL_BIT];
  assign pc_misaligned = |(pc & OFF_MASK);
  assign fetch_valid   = ce & ~stalled & ~pc_misaligned;
  // A misaligned pc never handshakes with memory, so it steps on its own to
  // let a corrective redirect through even with fetch_ready low.
  assign step          = ce & ~stalled & (fetch_ready | pc_misaligned);
  assign redir_taken   = ce ? win_onehot : '0;
  assign redir_pending = pending;

  // Fixed-priority arbiter: scan from the highest index down so the lowest
  // requesting channel is the last (and therefore final) assignment.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    win_valid  = 1'b0;
    win_addr   = '0;
    win_onehot = '0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        win_valid     = 1'b1;
        win_addr      = redir_addr[i*AW +: AW];
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-pc selection on a step: live redirect, then pending, then hold a
  // misaligned pc, otherwise sequential increment (wraps modulo 2^AW).
  always_comb begin
    next_pc = pc + PC_INC;
    if (win_valid)          next_pc = win_addr;
    else if (pending)       next_pc = pending_addr;
    else if (pc_misaligned) next_pc = pc;
  end

  // Control state: chip-enable, fetch pc and pending flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples values from before this edge, independent of order.
    if (rst) begin
      ce      <= 1'b0;
      pc      <= RESET_ADDR;
      pending <= 1'b0;
    end else if (!ce) begin
      ce      <= 1'b1;
      pc      <= RESET_ADDR;
      pending <= 1'b0;
    end else if (step) begin
      pc      <= next_pc;
      pending <= 1'b0;
    end else if (win_valid) begin
      pending <= 1'b1;
    end
  end

  // Pending target capture while fetch cannot advance; newest redirect wins.
  always_ff @(posedge clk) begin
    // NOTE: the address register has no reset; it is only read when pending
    // is set, and pending itself is reset.
    if (ce && !step && win_valid) pending_addr <= win_addr;
  end

endmodule
